// File: rtl/pipe_skid_reg_if.sv
// Valid/ready channel bundle used on both sides of pipe_skid_reg.
// Handshake rule: a word moves at a rising clk edge exactly when valid and
// ready are both high. The master must hold valid/data steady while
// valid=1 and ready=0. ready may be high with valid low.
interface pipe_skid_reg_if #(
  parameter int WIDTH = 32
) ();
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline register (skid buffer) between pipeline stages.
// The main register drives the downstream data. The skid register catches the
// one word that arrives while the downstream side stalls. All outputs come from
// registers, so there is no combinational path from dn.ready to up.ready.
// Optional feature: define PIPE_SKID_FLUSH_EN to add the 'flush' input. This
// input empties the buffer for a branch squash and leaves the data registers
// unchanged.
module pipe_skid_reg #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef PIPE_SKID_FLUSH_EN
  input  logic                    flush,
`endif
  pipe_skid_reg_if.slave          up,
  pipe_skid_reg_if.master         dn,
  output logic [1:0]              level,
  output logic [1:0]              dbg_state
);

  // Each state encoding equals the number of words held. The level output is
  // therefore the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;
  logic             in_fire;
  logic             out_fire;

  // State and data registers. Reset overrides any transfer in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= RST_VAL;
      skid_q <= RST_VAL;
    end else begin
      state <= state_nxt;
      if (load_main_in) begin
        main_q <= up.data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= up.data;
      end
    end
  end

  // Next state and data-register load controls.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          load_main_in = 1'b1;
          state_nxt    = BUSY;
        end
      end
      BUSY: begin
        case ({in_fire, out_fire})
          2'b11: load_main_in = 1'b1;
          2'b10: begin
            load_skid = 1'b1;
            state_nxt = FULL;
          end
          2'b01: state_nxt = EMPTY;   // main keeps its stale word
          default: state_nxt = BUSY;
        endcase
      end
      FULL: begin
        // up.ready is low here, so nothing new can enter this cycle.
        if (out_fire) begin
          load_main_skid = 1'b1;
          state_nxt      = BUSY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
`ifdef PIPE_SKID_FLUSH_EN
    // A squash drops every held word and any word arriving in the same cycle.
    if (flush) begin
      state_nxt      = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
`endif
  end

  // Handshake and status outputs are decoded only from the state register.
  always_comb begin
    up.ready  = (state != FULL);
    dn.valid  = (state != EMPTY);
    dn.data   = main_q;
    level     = state;
    dbg_state = state;
    in_fire   = up.valid & up.ready;
    out_fire  = dn.valid & dn.ready;
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg. It uses a vector table for the
// pass-through, back-pressure and drain traffic, then hand-written sequences
// for reset, streaming and flush.
module tb_pipe_skid_reg;

  localparam int W = 32;

  logic       clk;
  logic       rst;
`ifdef PIPE_SKID_FLUSH_EN
  logic       flush;
`endif
  logic [1:0] level;
  logic [1:0] dbg_state;

  pipe_skid_reg_if #(.WIDTH(W)) up_if ();
  pipe_skid_reg_if #(.WIDTH(W)) dn_if ();

  pipe_skid_reg #(.WIDTH(W), .RST_VAL('0)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef PIPE_SKID_FLUSH_EN
    .flush     (flush),
`endif
    .up        (up_if),
    .dn        (dn_if),
    .level     (level),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         ov;
    logic         ir;
    logic [1:0]   lvl;
    logic [W-1:0] od;
  } vec_t;

  vec_t vecs [14];

  // ---------------- driver tasks ----------------
  // Drives the inputs, then waits one clock edge. Outputs are sampled 1 ns later.
  task automatic apply(input logic iv, input logic [W-1:0] d, input logic ordy);
    up_if.valid = iv;
    up_if.data  = d;
    dn_if.ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ov, input logic ir,
                           input logic [1:0] lvl, input logic [W-1:0] od);
    check_bit ({tag, ".out_valid"}, dn_if.valid, ov);
    check_bit ({tag, ".in_ready"},  up_if.ready, ir);
    check_word({tag, ".level"},     {30'd0, level}, {30'd0, lvl});
    check_word({tag, ".out_data"},  dn_if.data, od);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    up_if.valid = 1'b0;
    up_if.data  = '0;
    dn_if.ready = 1'b0;
`ifdef PIPE_SKID_FLUSH_EN
    flush = 1'b0;
`endif

    //            iv  data     ordy  ov  ir  lvl   out_data
    // pass-through
    vecs[0]  = '{1'b1, 32'h11, 1'b1, 1'b1, 1'b1, 2'd1, 32'h11};
    vecs[1]  = '{1'b1, 32'h22, 1'b1, 1'b1, 1'b1, 2'd1, 32'h22};
    vecs[2]  = '{1'b1, 32'h33, 1'b1, 1'b1, 1'b1, 2'd1, 32'h33};
    vecs[3]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 2'd0, 32'h33};
    // back-pressure: A3 is offered while FULL and must wait
    vecs[4]  = '{1'b1, 32'hA1, 1'b0, 1'b1, 1'b1, 2'd1, 32'hA1};
    vecs[5]  = '{1'b1, 32'hA2, 1'b0, 1'b1, 1'b0, 2'd2, 32'hA1};
    vecs[6]  = '{1'b1, 32'hA3, 1'b0, 1'b1, 1'b0, 2'd2, 32'hA1};
    vecs[7]  = '{1'b1, 32'hA3, 1'b1, 1'b1, 1'b1, 2'd1, 32'hA2};
    vecs[8]  = '{1'b1, 32'hA3, 1'b1, 1'b1, 1'b1, 2'd1, 32'hA3};
    vecs[9]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 2'd0, 32'hA3};
    // fill then drain: level 2,1,0
    vecs[10] = '{1'b1, 32'hE1, 1'b0, 1'b1, 1'b1, 2'd1, 32'hE1};
    vecs[11] = '{1'b1, 32'hE2, 1'b0, 1'b1, 1'b0, 2'd2, 32'hE1};
    vecs[12] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 2'd1, 32'hE2};
    vecs[13] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 2'd0, 32'hE2};

    // ---------------- reset (transfer offered during reset is discarded) ----
    rst = 1'b1;
    apply(1'b1, 32'hDEAD_BEEF, 1'b1);
    apply(1'b1, 32'hDEAD_BEEF, 1'b1);
    check_all("reset", 1'b0, 1'b1, 2'd0, 32'h0);
    rst = 1'b0;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 14; i++) begin
      apply(vecs[i].iv, vecs[i].d, vecs[i].ordy);
      check_all($sformatf("vec%0d", i), vecs[i].ov, vecs[i].ir, vecs[i].lvl, vecs[i].od);
    end

    // ---------------- sustained streaming, no bubbles ----------------
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 32'h100 + i, 1'b1);
      check_all($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, 32'h100 + i);
    end
    apply(1'b0, 32'h0, 1'b1);
    check_all("stream_end", 1'b0, 1'b1, 2'd0, 32'h107);

    // ---------------- reset mid-operation ----------------
    apply(1'b1, 32'hB1, 1'b0);
    apply(1'b1, 32'hB2, 1'b0);
    check_all("b_full", 1'b1, 1'b0, 2'd2, 32'hB1);
    rst = 1'b1;
    apply(1'b1, 32'hBB, 1'b1);
    rst = 1'b0;
    check_all("mid_rst", 1'b0, 1'b1, 2'd0, 32'h0);
    apply(1'b1, 32'hC1, 1'b0);
    check_all("c1_in", 1'b1, 1'b1, 2'd1, 32'hC1);
    apply(1'b0, 32'h0, 1'b1);
    check_all("c1_alone", 1'b0, 1'b1, 2'd0, 32'hC1);

`ifdef PIPE_SKID_FLUSH_EN
    // ---------------- flush from FULL, D1 offered in the same cycle -------
    apply(1'b1, 32'hF1, 1'b0);
    apply(1'b1, 32'hF2, 1'b0);
    check_all("f_full", 1'b1, 1'b0, 2'd2, 32'hF1);
    flush = 1'b1;
    apply(1'b1, 32'hD1, 1'b1);
    flush = 1'b0;
    check_all("flush", 1'b0, 1'b1, 2'd0, 32'hF1);
    apply(1'b0, 32'h0, 1'b1);
    check_all("flush_idle", 1'b0, 1'b1, 2'd0, 32'hF1);
    // flush in BUSY while in_fire is attempted: D1 must be dropped
    apply(1'b1, 32'hF3, 1'b0);
    flush = 1'b1;
    apply(1'b1, 32'hD1, 1'b0);
    flush = 1'b0;
    check_all("flush_busy", 1'b0, 1'b1, 2'd0, 32'hF3);
    apply(1'b1, 32'hF4, 1'b1);
    check_all("after_flush", 1'b1, 1'b1, 2'd1, 32'hF4);
    apply(1'b0, 32'h0, 1'b1);
    check_all("after_flush_drain", 1'b0, 1'b1, 2'd0, 32'hF4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Two-entry elastic pipeline register (skid buffer) placed between 0dMIPS pipeline stages.
- Replaces the bare enable-gated flip-flop bank where the downstream stage must stall the upstream stage through a valid/ready handshake.
- All outputs come straight from registers. The ready path back to the upstream stage is registered and has no combinational path from out_ready.
- Accepts one word per cycle at full throughput. Data order is preserved and no word is dropped or duplicated.

Parameters:
WIDTH, 32, payload width in bits (MIPS word)
RST_VAL, 0, value loaded into both data registers on reset

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  upstream presents in_data
in_ready  output  1  block will accept in_data this cycle
in_data  input  WIDTH  upstream payload
out_valid  output  1  out_data holds a valid word
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  WIDTH  head-of-buffer payload
level  output  2  words held: 0, 1 or 2

Behaviour:
- Transfer rules:
  - Input transfer (in_fire) = in_valid & in_ready at a rising clk.
  - Output transfer (out_fire) = out_valid & out_ready at a rising clk.
- Storage: main register drives out_data; skid register holds one overflow word. Three states:
  - EMPTY: level=0, out_valid=0, in_ready=1.
  - BUSY: level=1, out_valid=1, in_ready=1.
  - FULL: level=2, out_valid=1, in_ready=0.
- Transitions:
  - EMPTY: in_valid → main<=in_data, go to BUSY. Otherwise stay.
  - BUSY, in_fire & out_fire → main<=in_data, stay BUSY.
  - BUSY, in_fire & !out_fire → skid<=in_data, go to FULL.
  - BUSY, !in_fire & out_fire → go to EMPTY. main keeps its stale value.
  - BUSY, neither fires → hold.
  - FULL, out_ready → main<=skid, go to BUSY. in_valid is ignored because in_ready=0.
  - FULL, !out_ready → hold all.
- Latency: a word accepted at edge N is presented on out_data/out_valid after edge N (one cycle) when the buffer was EMPTY or passing through in BUSY.
- Stability: out_data must stay stable while out_valid=1 and out_ready=0.
- Output sourcing: in_ready, out_valid and level are decoded only from the state register.
- Reset (rst high at an edge):
  - state=EMPTY, main=skid=out_data=RST_VAL, out_valid=0, level=0, in_ready=1.
  - Any transfer attempted in the same cycle is discarded.
  - Reset mid-operation drops buffered words with no partial state.
- Throughput: with out_ready held at 1, one word per cycle is sustained with no bubbles.
- Error case: FULL never accepts a third word.
- Protocol constraint: in_valid/in_data must not be withdrawn while in_valid=1 and in_ready=0. The block does not check this.

Optional Feature:
- Macro: PIPE_SKID_FLUSH_EN.
- When defined:
  - Adds input port flush (1 bit, after rst in the port list).
  - flush high at an edge forces state=EMPTY. Data registers keep their contents.
  - in_fire in the same cycle is dropped.
  - Priority order: rst > flush > normal transitions.
  - Used for branch squash.
- When undefined: the port is absent and behaviour is exactly as above.

Test Plan:
1. Reset check: rst=1 for 2 cycles, then released → out_valid=0, in_ready=1, level=0, out_data=0x00000000.
2. Pass-through: out_ready=1, stream 0x11,0x22,0x33 on consecutive cycles → each appears one cycle later on consecutive cycles, in_ready stays 1, level stays 1.
3. Back-pressure: out_ready=0, send 0xA1 then 0xA2 → level=2, in_ready=0, out_data=0xA1. Then offer 0xA3 → not accepted. Raise out_ready → out_data sequence 0xA1,0xA2,0xA3 with no loss or duplication.
4. Drain: from FULL, out_ready=1 with in_valid=0 → level goes 2,1,0 on successive edges and out_valid falls after the second word.
5. Reset mid-operation: from FULL with 0xB1/0xB2 held, pulse rst for 1 cycle → next cycle level=0, out_valid=0. A new word 0xC1 then emerges alone.
6. With PIPE_SKID_FLUSH_EN defined: in FULL, assert flush together with in_valid carrying 0xD1 → next cycle level=0 and 0xD1 is never output.
